command_sequencer: RTL and testbench
====================================

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 SHALL have the ports listed in REQ-002 to REQ-019; CLOCK is the single clock and the bit-time clock; all state updates on its rising edge.
REQ-002 CLOCK  in  1  bit-time clock, sole clock.
REQ-003 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-004 TE  in  1  word-end strobe, high one CLOCK at last bit of every word time.
REQ-005 WT  in  7  current word-time number 0..107, stable while TE=1.
REQ-006 SW_GO, SW_NO_GO  in  1 each  run / halt-after-current-command switches, level.
REQ-007 SW_BP  in  1  breakpoint enable, level.
REQ-008 STEP  in  1  single-command request, one-CLOCK pulse.
REQ-009 SET_N, SET_N_VAL  in  1, 7  manual next-command load strobe and value.
REQ-010 CMD_N, CMD_T, CMD_L  in  7 each  next-command, timing and location fields of the command register.
REQ-011 CMD_DEFER, CMD_BP  in  1 each  deferred-execution bit, breakpoint bit.
REQ-012 CMD_N..CMD_BP SHALL be sampled only in the DECODE cycle, i.e. the CLOCK after CMD_LOAD.
REQ-013 RC  out  1  read-command gate, high in state READ.
REQ-014 TR  out  1  transfer gate, high in state XFER.
REQ-015 WL  out  1  waiting-for-L indicator, high in state WAIT.
REQ-016 HALTED  out  1  high in state HALT.
REQ-017 CMD_LOAD  out  1  one-CLOCK strobe: load command register from drum.
REQ-018 N_REG  out  7  registered next-command word time.
REQ-019 WORD_CNT  out  7  words transferred by current/last command.

Function
REQ-020 SHALL implement states HALT, READ, DECODE, WAIT, XFER; outputs registered and decoded from state only.
REQ-021 All word-time arithmetic SHALL be mod 108; pred(x) = (x+107) mod 108; inputs >107 SHALL be treated as never matching.
REQ-022 HALT: on SET_N=1 load N_REG <= SET_N_VAL; SET_N SHALL be ignored in every other state.
REQ-023 HALT -> READ on the next TE when run = (SW_GO & ~SW_NO_GO) or a STEP pulse was latched; STEP latched while HALTED, held until consumed.
REQ-024 step_mode flag SHALL set when READ is entered via STEP with run=0, cleared on entry to HALT.
REQ-025 READ: at TE with WT == N_REG -> CMD_LOAD=1 that same CLOCK (combinational from state&TE&match), next state DECODE.
REQ-026 DECODE (exactly one CLOCK): N_REG <= CMD_N, latch T_reg <= CMD_T, L_reg <= CMD_L, bp_reg <= CMD_BP, WORD_CNT <= 0; next XFER if CMD_DEFER=0, else WAIT.
REQ-027 WAIT: at TE with WT == pred(L_reg) -> XFER, so the first transferred word is L.
REQ-028 XFER: WORD_CNT increments on every TE; at TE with WT == pred(T_reg) transfer ends (last word is T-1).
REQ-029 If the end condition already holds on the first XFER TE, exactly one word SHALL be transferred (WORD_CNT=1); the first XFER TE never re-evaluated for wrap, a command with T == start word SHALL run 108 words (WORD_CNT=108).
REQ-030 End of XFER -> HALT if step_mode, or SW_NO_GO=1, or (bp_reg & SW_BP); else -> READ.
REQ-031 SW_NO_GO/SW_GO changes SHALL NOT abort READ, WAIT or XFER; halting occurs only per REQ-030.
REQ-032 WORD_CNT SHALL hold its value in HALT and READ until the next DECODE.
REQ-033 TE with no match in READ/WAIT/XFER leaves state unchanged; STEP outside HALT ignored.

Reset
REQ-034 rst=0 at a rising edge SHALL force HALT, RC=TR=WL=CMD_LOAD=0, HALTED=1, N_REG=0, WORD_CNT=0, step_mode=0, STEP latch cleared, regardless of state (including mid-XFER).
REQ-035 First state change after rst returns to 1 SHALL require a fresh run condition per REQ-023.

Verification
REQ-036 Reset mid-XFER: rst=0 for 1 CLOCK during TR=1 -> next edge TR=0, HALTED=1, N_REG=0, WORD_CNT=0.
REQ-037 Immediate: N_REG=5, SW_GO=1, CMD_N=20, T=10, DEFER=0 -> CMD_LOAD at WT=5 TE, TR during words 6..9, WORD_CNT=4, N_REG=20, RC=1 afterwards.
REQ-038 Deferred wrap: CMD_L=106, T=2, DEFER=1 -> WL until TE WT=105, TR words 106,107,0,1, WORD_CNT=4.
REQ-039 Breakpoint: CMD_BP=1, SW_BP=1 -> HALTED=1 after transfer; same with SW_BP=0 -> RC=1.
REQ-040 Step: SW_GO=0, SET_N=1 val 40, STEP pulse -> one command executed, CMD_LOAD once at WT=40, then HALTED=1.
REQ-041 Full loop: immediate read at N=50, T=51 -> 108 words transferred, WORD_CNT=108.

Source files
------------

// File: rtl/command_sequencer.sv
// Drum-machine command sequencer: reads a command at word time N, then transfers
// words from L (deferred) or the next word (immediate) up to T-1, all mod 108.
module command_sequencer (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       TE,
  input  logic [6:0] WT,
  input  logic       SW_GO,
  input  logic       SW_NO_GO,
  input  logic       SW_BP,
  input  logic       STEP,
  input  logic       SET_N,
  input  logic [6:0] SET_N_VAL,
  input  logic [6:0] CMD_N,
  input  logic [6:0] CMD_T,
  input  logic [6:0] CMD_L,
  input  logic       CMD_DEFER,
  input  logic       CMD_BP,
  output logic       RC,
  output logic       TR,
  output logic       WL,
  output logic       HALTED,
  output logic       CMD_LOAD,
  output logic [6:0] N_REG,
  output logic [6:0] WORD_CNT
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_READ   = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_XFER   = 3'd4
  } state_t;

  state_t     state_r, state_nx_s;
  logic [6:0] n_reg_r, t_reg_r, l_reg_r, word_cnt_r;
  logic       bp_reg_r, step_mode_r, step_lat_r;
  logic       rc_r, tr_r, wl_r, halted_r;
  logic       run_s, stop_s;

  function automatic logic [6:0] wt_pred(input logic [6:0] x);
    if (x == 7'd0) return 7'd107;
    else           return x - 7'd1;
  endfunction

  // Word times above 107 do not exist on the drum, so they can never match.
  function automatic logic wt_hit(input logic [6:0] wt, input logic [6:0] target);
    return (wt <= 7'd107) && (target <= 7'd107) && (wt == target);
  endfunction

  function automatic logic wt_hit_pred(input logic [6:0] wt, input logic [6:0] x);
    return (x <= 7'd107) && wt_hit(wt, wt_pred(x));
  endfunction

  // Next-state decode
  always_comb begin
    run_s      = SW_GO & ~SW_NO_GO;
    stop_s     = step_mode_r | SW_NO_GO | (bp_reg_r & SW_BP);
    state_nx_s = state_r;
    case (state_r)
      S_HALT: begin
        if (TE && (run_s || step_lat_r || STEP)) state_nx_s = S_READ;
        else                                     state_nx_s = S_HALT;
      end
      S_READ: begin
        if (TE && wt_hit(WT, n_reg_r)) state_nx_s = S_DECODE;
        else                           state_nx_s = S_READ;
      end
      S_DECODE: begin
        if (CMD_DEFER) state_nx_s = S_WAIT;
        else           state_nx_s = S_XFER;
      end
      S_WAIT: begin
        if (TE && wt_hit_pred(WT, l_reg_r)) state_nx_s = S_XFER;
        else                                state_nx_s = S_WAIT;
      end
      S_XFER: begin
        if (TE && wt_hit_pred(WT, t_reg_r)) begin
          if (stop_s) state_nx_s = S_HALT;
          else        state_nx_s = S_READ;
        end else begin
          state_nx_s = S_XFER;
        end
      end
      default: state_nx_s = S_HALT;
    endcase
  end

  // State, registered state-decoded outputs and command datapath
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_r     <= S_HALT;
      n_reg_r     <= 7'd0;
      t_reg_r     <= 7'd0;
      l_reg_r     <= 7'd0;
      word_cnt_r  <= 7'd0;
      bp_reg_r    <= 1'b0;
      step_mode_r <= 1'b0;
      step_lat_r  <= 1'b0;
      rc_r        <= 1'b0;
      tr_r        <= 1'b0;
      wl_r        <= 1'b0;
      halted_r    <= 1'b1;
    end else begin
      state_r  <= state_nx_s;
      rc_r     <= (state_nx_s == S_READ);
      tr_r     <= (state_nx_s == S_XFER);
      wl_r     <= (state_nx_s == S_WAIT);
      halted_r <= (state_nx_s == S_HALT);
      case (state_r)
        S_HALT: begin
          if (SET_N) n_reg_r <= SET_N_VAL;
          // A start without the run condition can only come from STEP.
          if (state_nx_s == S_READ) begin
            step_mode_r <= ~run_s;
            step_lat_r  <= 1'b0;
          end else if (STEP) begin
            step_lat_r <= 1'b1;
          end
        end
        S_DECODE: begin
          n_reg_r    <= CMD_N;
          t_reg_r    <= CMD_T;
          l_reg_r    <= CMD_L;
          bp_reg_r   <= CMD_BP;
          word_cnt_r <= 7'd0;
        end
        S_XFER: begin
          if (TE) word_cnt_r <= word_cnt_r + 7'd1;
          if (state_nx_s == S_HALT) step_mode_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign CMD_LOAD = (state_r == S_READ) && TE && wt_hit(WT, n_reg_r);
  assign RC       = rc_r;
  assign TR       = tr_r;
  assign WL       = wl_r;
  assign HALTED   = halted_r;
  assign N_REG    = n_reg_r;
  assign WORD_CNT = word_cnt_r;

endmodule

// File: tb/tb_command_sequencer.sv
// Scoreboard bench for command_sequencer: a 4-bit-per-word drum timing generator,
// directed commands, and a monitor checking each command load and transfer end.
module tb_command_sequencer;

  logic       CLOCK, rst, TE, SW_GO, SW_NO_GO, SW_BP, STEP, SET_N, CMD_DEFER, CMD_BP;
  logic [6:0] WT, SET_N_VAL, CMD_N, CMD_T, CMD_L;
  logic       RC, TR, WL, HALTED, CMD_LOAD;
  logic [6:0] N_REG, WORD_CNT;

  typedef struct {
    logic       is_end;
    int         a;      // load: WT; end: WORD_CNT
    int         b;      // end: first word
    int         c;      // end: last word
    int         d;      // end: N_REG
    logic       halted;
    logic       rc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  command_sequencer dut (
    .CLOCK(CLOCK), .rst(rst), .TE(TE), .WT(WT), .SW_GO(SW_GO), .SW_NO_GO(SW_NO_GO),
    .SW_BP(SW_BP), .STEP(STEP), .SET_N(SET_N), .SET_N_VAL(SET_N_VAL), .CMD_N(CMD_N),
    .CMD_T(CMD_T), .CMD_L(CMD_L), .CMD_DEFER(CMD_DEFER), .CMD_BP(CMD_BP), .RC(RC),
    .TR(TR), .WL(WL), .HALTED(HALTED), .CMD_LOAD(CMD_LOAD), .N_REG(N_REG),
    .WORD_CNT(WORD_CNT)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Drum timing: 4 bits per word, TE on the last bit, WT cycles 0..107.
  initial begin
    int b, w;
    b = 0; w = 0; TE = 1'b0; WT = 7'd0;
    forever begin
      @(posedge CLOCK); #1;
      b = (b + 1) % 4;
      if (b == 0) w = (w + 1) % 108;
      TE = (b == 3);
      WT = 7'(w);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each CMD_LOAD and at each transfer end.
  initial begin
    logic tr_prev, first_seen;
    int   first_wt, last_wt;
    exp_t e;
    tr_prev = 1'b0; first_seen = 1'b0; first_wt = 0; last_wt = 0;
    forever begin
      @(negedge CLOCK);
      if (!rst) begin
        tr_prev    = 1'b0;
        first_seen = 1'b0;
      end else begin
        if (TE && TR) begin
          if (!first_seen) first_wt = int'(WT);
          first_seen = 1'b1;
          last_wt    = int'(WT);
        end
        if (CMD_LOAD) begin
          checks++;
          if (sb.size() == 0 || sb[0].is_end) begin
            errors++;
            $display("FAIL load_unexpected: got load at WT %0d expected none", WT);
          end else begin
            e = sb.pop_front();
            check("load_wt", int'(WT), e.a);
          end
        end
        if (tr_prev && !TR) begin
          checks++;
          if (sb.size() == 0 || !sb[0].is_end) begin
            errors++;
            $display("FAIL end_unexpected: got transfer end cnt %0d expected none", WORD_CNT);
          end else begin
            e = sb.pop_front();
            check("word_cnt", int'(WORD_CNT), e.a);
            check("first_word", first_wt, e.b);
            check("last_word", last_wt, e.c);
            check("n_reg_after", int'(N_REG), e.d);
            check("halted_after", int'(HALTED), int'(e.halted));
            check("rc_after", int'(RC), int'(e.rc));
          end
          first_seen = 1'b0;
        end
        tr_prev = TR;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK); #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return HALTED;
      1:       return TR;
      2:       return RC;
      3:       return WL;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int budget);
    int n;
    n = 0;
    while (!sig(which) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!sig(which)) begin
      errors++;
      $display("FAIL timeout_%s: got 0 after %0d cycles expected 1", name, budget);
    end
  endtask

  task automatic push_load(input int wt);
    exp_t e;
    e = '{is_end: 1'b0, a: wt, b: 0, c: 0, d: 0, halted: 1'b0, rc: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_end(input int cnt, input int first, input int last, input int n,
                          input logic halted, input logic rc);
    exp_t e;
    e = '{is_end: 1'b1, a: cnt, b: first, c: last, d: n, halted: halted, rc: rc};
    sb.push_back(e);
  endtask

  task automatic set_n(input int v);
    SET_N = 1'b1; SET_N_VAL = 7'(v);
    tick();
    SET_N = 1'b0;
    check("set_n", int'(N_REG), v);
  endtask

  task automatic set_cmd(input int n, input int t, input int l, input logic defer, input logic bp);
    CMD_N = 7'(n); CMD_T = 7'(t); CMD_L = 7'(l); CMD_DEFER = defer; CMD_BP = bp;
  endtask

  task automatic step_pulse();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; SW_GO = 1'b0; SW_NO_GO = 1'b0; SW_BP = 1'b0; STEP = 1'b0;
    SET_N = 1'b0; SET_N_VAL = 7'd0;
    set_cmd(0, 0, 0, 1'b0, 1'b0);
    repeat (3) tick();
    check("rst_halted", int'(HALTED), 1);
    check("rst_rc", int'(RC), 0);
    check("rst_tr", int'(TR), 0);
    check("rst_wl", int'(WL), 0);
    check("rst_n_reg", int'(N_REG), 0);
    check("rst_word_cnt", int'(WORD_CNT), 0);
    rst = 1'b1;
    tick();

    // Immediate command at N=5, then a wrapping one halted by NO_GO mid-read
    set_n(5);
    set_cmd(20, 10, 0, 1'b0, 1'b0);
    push_load(5);  push_end(4, 6, 9, 20, 1'b0, 1'b1);
    push_load(20); push_end(97, 21, 9, 20, 1'b1, 1'b0);
    SW_GO = 1'b1;
    wait_sig("imm_tr", 1, 1200);
    wait_sig("imm_rc", 2, 100);
    SW_NO_GO = 1'b1;
    wait_sig("imm_halt", 0, 1200);
    SW_GO = 1'b0; SW_NO_GO = 1'b0;

    // Single step from N=40
    set_n(40);
    set_cmd(45, 43, 0, 1'b0, 1'b0);
    push_load(40); push_end(2, 41, 42, 45, 1'b1, 1'b0);
    step_pulse();
    wait_sig("step_tr", 1, 1200);
    wait_sig("step_halt", 0, 1200);

    // Deferred transfer wrapping through word 0
    set_n(70);
    set_cmd(0, 2, 106, 1'b1, 1'b0);
    push_load(70); push_end(4, 106, 1, 0, 1'b1, 1'b0);
    step_pulse();
    wait_sig("defer_wl", 3, 1200);
    wait_sig("defer_tr", 1, 1200);
    wait_sig("defer_halt", 0, 1200);

    // Breakpoint honoured, then ignored with SW_BP=0; one-word transfers
    set_n(10);
    set_cmd(12, 14, 0, 1'b0, 1'b1);
    SW_BP = 1'b1;
    push_load(10); push_end(3, 11, 13, 12, 1'b1, 1'b0);
    push_load(12); push_end(1, 13, 13, 12, 1'b0, 1'b1);
    push_load(12); push_end(1, 13, 13, 12, 1'b1, 1'b0);
    SW_GO = 1'b1;
    wait_sig("bp_tr", 1, 1200);
    wait_sig("bp_halt", 0, 1200);
    SW_BP = 1'b0;
    wait_sig("nobp_tr", 1, 1200);
    wait_sig("nobp_rc", 2, 100);
    SW_NO_GO = 1'b1;
    wait_sig("nobp_halt", 0, 1200);
    SW_GO = 1'b0; SW_NO_GO = 1'b0;

    // Full drum loop: T equals the start word
    set_n(50);
    set_cmd(50, 51, 0, 1'b0, 1'b0);
    push_load(50); push_end(108, 51, 50, 50, 1'b1, 1'b0);
    step_pulse();
    wait_sig("loop_tr", 1, 1200);
    wait_sig("loop_halt", 0, 1200);

    // Reset in the middle of a transfer
    set_n(5);
    set_cmd(9, 100, 0, 1'b0, 1'b0);
    push_load(5);
    step_pulse();
    wait_sig("mid_tr", 1, 1200);
    repeat (8) tick();
    rst = 1'b0;
    tick();
    check("midrst_tr", int'(TR), 0);
    check("midrst_halted", int'(HALTED), 1);
    check("midrst_n_reg", int'(N_REG), 0);
    check("midrst_word_cnt", int'(WORD_CNT), 0);
    rst = 1'b1;
    repeat (12) tick();
    check("post_rst_halted", int'(HALTED), 1);
    check("post_rst_rc", int'(RC), 0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("scoreboard_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
